// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encodings, prefix constants and game scan codes for the PS/2 keyboard path
package ps2_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KEY_NONE       = 8'h00;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronises and filters the PS/2 lines, then deframes 11-bit keyboard frames with timeout
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN) + 1;

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       dat_sync_q, dat_sync_d;
    logic             filt_q, filt_d;
    logic [FW-1:0]    filt_cnt_q, filt_cnt_d;
    logic             fall;
    logic             dat;
    rx_state_t        state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_ok_q;
    logic [CNT_W-1:0] tmo_q;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    // two-stage synchronisers and a level filter that flips only after FILTER_LEN differing samples
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            filt_cnt_d = filt_cnt_q + 1'b1;
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d     = clk_sync_q[1];
                filt_cnt_d = '0;
            end
        end
        fall = filt_q & ~filt_d;
        dat  = dat_sync_q[1];
    end

    // input conditioning registers; idle PS/2 lines rest high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // frame FSM: start, eight data bits LSB first, odd parity, stop; a stalled frame is abandoned
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_q       <= (state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;
            if (fall) begin
                case (state_q)
                    RX_IDLE: begin
                        bit_cnt_q <= '0;
                        if (dat) frame_err_q <= 1'b1;
                        else     state_q     <= RX_DATA;
                    end
                    RX_DATA: begin
                        shift_q   <= {dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_ok_q <= odd_parity_ok(shift_q, dat);
                        state_q  <= RX_STOP;
                    end
                    default: begin
                        if (dat && par_ok_q) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end
                endcase
            end else if (state_q != RX_IDLE && tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_q     <= RX_IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 make/break/E0 byte streams into the currently held key code
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    dec_state_t dstate_q, dstate_d;
    logic [7:0] code_q, code_d;
    logic       ext_q, ext_d;
    logic       event_q, event_d;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // prefix tracking; the latest make wins and a break only clears the key it names
    always_comb begin
        dstate_d = dstate_q;
        code_d   = code_q;
        ext_d    = ext_q;
        if (rx_valid) begin
            case (dstate_q)
                D_IDLE: begin
                    if (rx_byte == PS2_PREFIX_EXT)      dstate_d = D_E0;
                    else if (rx_byte == PS2_PREFIX_BRK) dstate_d = D_F0;
                    else begin
                        code_d = rx_byte;
                        ext_d  = 1'b0;
                    end
                end
                D_E0: begin
                    if (rx_byte == PS2_PREFIX_BRK) dstate_d = D_E0F0;
                    else if (rx_byte != PS2_PREFIX_EXT) begin
                        code_d   = rx_byte;
                        ext_d    = 1'b1;
                        dstate_d = D_IDLE;
                    end
                end
                default: begin
                    if (rx_byte == code_q && ext_q == (dstate_q == D_E0F0)) begin
                        code_d = KEY_NONE;
                        ext_d  = 1'b0;
                    end
                    dstate_d = D_IDLE;
                end
            endcase
        end
        event_d = (code_d != code_q) || (ext_d != ext_q);
    end

    // held-key registers and change pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            dstate_q <= D_IDLE;
            code_q   <= KEY_NONE;
            ext_q    <= 1'b0;
            event_q  <= 1'b0;
        end else begin
            dstate_q <= dstate_d;
            code_q   <= code_d;
            ext_q    <= ext_d;
            event_q  <= event_d;
        end
    end

    assign key_code  = code_q;
    assign key_ext   = ext_q;
    assign key_event = event_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: drives PS/2 frames and checks held key, events and errors against a byte-level model
module tb_ps2_key_decoder;

    localparam int H   = 20;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_event;
    logic       frame_err;

    int   n_chk = 0;
    int   n_fail = 0;
    int   ev_cnt = 0;
    int   err_cnt = 0;
    bit   chk_en = 1'b0;
    logic [7:0] exp_code = 8'h00;
    bit   exp_ext = 1'b0;
    bit   pend_ext = 1'b0;
    bit   pend_brk = 1'b0;
    int   exp_ev = 0;

    logic [7:0] keys [9] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74};

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (key_event) ev_cnt++;
        if (frame_err) err_cnt++;
        if (chk_en) begin
            check("key_code", int'(key_code), int'(exp_code));
            check("key_ext", int'(key_ext), int'(exp_ext));
        end
    end

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] oc;
        bit oe;
        oc = exp_code;
        oe = exp_ext;
        if (pend_brk) begin
            if (b == exp_code && exp_ext == pend_ext) begin
                exp_code = 8'h00;
                exp_ext  = 1'b0;
            end
            pend_brk = 1'b0;
            pend_ext = 1'b0;
        end else if (b == 8'hE0) begin
            pend_ext = 1'b1;
        end else if (b == 8'hF0) begin
            pend_brk = 1'b1;
        end else begin
            exp_code = b;
            exp_ext  = pend_ext;
            pend_ext = 1'b0;
        end
        exp_ev = (oc != exp_code || oe != exp_ext) ? 1 : 0;
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        ev_cnt  = 0;
        err_cnt = 0;
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        chk_en = 1'b0;
        send_bit(f[10]);
        if (!bad_par && !bad_stop) model_byte(b);
        else exp_ev = 0;
        repeat (H) @(negedge clk);
        ps2_data = 1'b1;
        chk_en = 1'b1;
        check("key_event_count", ev_cnt, exp_ev);
        check("frame_err_count", err_cnt, (bad_par || bad_stop) ? 1 : 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_key_code", int'(key_code), 0);
        check("reset_key_ext", int'(key_ext), 0);
        check("reset_key_event", int'(key_event), 0);
        check("reset_frame_err", int'(frame_err), 0);
        chk_en = 1'b1;

        send_frame(8'h1D);
        check("t1_make_code", int'(key_code), 'h1D);
        check("t1_model_code", int'(exp_code), 'h1D);
        send_frame(8'hF0);
        send_frame(8'h1D);
        check("t1_break_code", int'(key_code), 0);

        send_frame(8'hE0);
        send_frame(8'h75);
        check("t2_up_code", int'(key_code), 'h75);
        check("t2_up_ext", int'(key_ext), 1);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("t2_plain_break_ignored", int'(key_code), 'h75);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("t2_ext_break_code", int'(key_code), 0);
        check("t2_ext_break_ext", int'(key_ext), 0);

        send_frame(8'h1C);
        send_frame(8'h23);
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("t3_last_key_wins", int'(key_code), 'h23);
        for (int i = 0; i < 3; i++) send_frame(8'h23);
        check("t3_repeat_no_event", ev_cnt, 0);

        send_frame(8'h1B, 1'b1, 1'b0);
        check("t4_parity_err_code", int'(key_code), 'h23);
        send_frame(8'h1B);
        check("t4_recover_code", int'(key_code), 'h1B);
        send_frame(8'h23, 1'b0, 1'b1);
        check("t4_stop_err_code", int'(key_code), 'h1B);

        ev_cnt = 0;
        err_cnt = 0;
        send_bit(1'b1);
        repeat (H) @(negedge clk);
        check("bad_start_err", err_cnt, 1);

        ev_cnt = 0;
        err_cnt = 0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (TMO - 50) @(negedge clk);
        check("t5_no_early_timeout", err_cnt, 0);
        repeat (TMO * 2 / 5) @(negedge clk);
        check("t5_timeout_err", err_cnt, 1);
        check("t5_timeout_no_event", ev_cnt, 0);
        send_frame(8'h76);
        check("t5_after_timeout_code", int'(key_code), 'h76);

        send_frame(8'h23);
        check("t6_pre_reset_code", int'(key_code), 'h23);
        begin
            logic [10:0] f;
            f = {1'b1, ~^8'h23, 8'h23, 1'b0};
            for (int i = 0; i < 5; i++) send_bit(f[i]);
            chk_en = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            exp_code = 8'h00;
            exp_ext = 1'b0;
            pend_ext = 1'b0;
            pend_brk = 1'b0;
            check("t6_reset_code", int'(key_code), 0);
            check("t6_reset_ext", int'(key_ext), 0);
            check("t6_reset_event", int'(key_event), 0);
            check("t6_reset_err", int'(frame_err), 0);
            chk_en = 1'b1;
            ev_cnt = 0;
            for (int i = 5; i < 11; i++) send_bit(f[i]);
            repeat (TMO + 200) @(negedge clk);
            check("t6_aborted_no_event", ev_cnt, 0);
            check("t6_aborted_code", int'(key_code), 0);
        end

        for (int it = 0; it < 30; it++) begin
            int r;
            logic [7:0] k;
            logic [7:0] hc;
            bit e;
            bit he;
            r  = $urandom_range(0, 9);
            k  = keys[$urandom_range(0, 8)];
            e  = 1'($urandom_range(0, 1));
            hc = exp_code;
            he = exp_ext;
            case (r)
                0, 1, 2, 3: begin
                    if (e) send_frame(8'hE0);
                    send_frame(k);
                end
                4, 5: begin
                    if (he) send_frame(8'hE0);
                    send_frame(8'hF0);
                    send_frame(hc);
                end
                6: begin
                    if (e) send_frame(8'hE0);
                    send_frame(8'hF0);
                    send_frame(k);
                end
                7: begin
                    if (he) send_frame(8'hE0);
                    send_frame(hc == 8'h00 ? k : hc);
                end
                8: send_frame(8'($urandom), e, ~e);
                default: send_frame(8'($urandom));
            endcase
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
